pipe_stage_chain: RTL and testbench

//  Generic in-order pipeline register chain: DEPTH stages of WIDTH-bit payload, each with a valid bit.
//  Per-stage stall and flush controls; optional bubble collapsing.

---
 rtl/pipe_stage_chain.sv | 136 +++++++++++++
 tb/tb_pipe_stage_chain.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// ============================================================================
// Module      : pipe_stage_chain
// Description : In-order pipeline register chain with per-stage stall/flush,
//               optional bubble collapsing, occupancy and perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_chain #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 5,
   parameter int COLLAPSE = 0,
   parameter int CNTW     = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         in_ready,
   input  logic [DEPTH-1:0]             stall_req,
   input  logic [DEPTH-1:0]             flush,
   output logic [DEPTH-1:0]             stage_valid,
   output logic [DEPTH*WIDTH-1:0]       stage_data,
   output logic                         out_valid,
   output logic [WIDTH-1:0]             out_data,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic [CNTW-1:0]              retire_cnt,
   output logic [CNTW-1:0]              bubble_cnt
);

   localparam int OCCW = $clog2(DEPTH+1);

   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] data;
   } stage_t;

   stage_t            stage_q [DEPTH];
   stage_t            stage_d [DEPTH];
   logic [OCCW-1:0]   occ_q;
   logic [OCCW-1:0]   occ_d;
   logic [CNTW-1:0]   retire_cnt_q;
   logic [CNTW-1:0]   retire_cnt_d;
   logic [CNTW-1:0]   bubble_cnt_q;
   logic [CNTW-1:0]   bubble_cnt_d;

   logic [DEPTH-1:0]  move;
   logic [DEPTH-1:0]  accept;
   logic [DEPTH-1:0]  kill;
   logic              w_take;

   // Handshake resolves from the oldest stage back toward the producer;
   // kill[i] is set when any flush bit at index >= i is asserted.
   always_comb begin
      move   = '0;
      accept = '0;
      kill   = '0;
      move[DEPTH-1]   = !stall_req[DEPTH-1];
      accept[DEPTH-1] = move[DEPTH-1] | ((COLLAPSE != 0) & !stage_q[DEPTH-1].valid);
      kill[DEPTH-1]   = flush[DEPTH-1];
      for (int i = DEPTH-2; i >= 0; i--) begin
         move[i]   = !stall_req[i] & accept[i+1];
         accept[i] = move[i] | ((COLLAPSE != 0) & !stage_q[i].valid);
         kill[i]   = flush[i] | kill[i+1];
      end
   end

   assign in_ready = accept[0] & ~|flush;
   assign w_take   = in_valid & in_ready;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i];
      end
      if (accept[0]) begin
         stage_d[0].valid = w_take;
         if (w_take) begin
            stage_d[0].data = in_data;
         end
      end
      for (int i = 1; i < DEPTH; i++) begin
         if (accept[i]) begin
            stage_d[i].valid = stage_q[i-1].valid & move[i-1] & !kill[i-1];
            if (stage_q[i-1].valid & move[i-1] & !kill[i-1]) begin
               stage_d[i].data = stage_q[i-1].data;
            end
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (kill[i]) begin
            stage_d[i].valid = 1'b0;
         end
      end
      occ_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occ_d = occ_d + OCCW'(stage_d[i].valid);
      end
   end

   assign out_valid    = stage_q[DEPTH-1].valid & move[DEPTH-1];
   assign out_data     = stage_q[DEPTH-1].data;
   assign retire_cnt_d = retire_cnt_q + CNTW'(out_valid);
   assign bubble_cnt_d = bubble_cnt_q + CNTW'(!out_valid);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
         occ_q        <= '0;
         retire_cnt_q <= '0;
         bubble_cnt_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
         end
         occ_q        <= occ_d;
         retire_cnt_q <= retire_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   generate
      for (genvar g = 0; g < DEPTH; g++) begin : g_out
         assign stage_valid[g]               = stage_q[g].valid;
         assign stage_data[g*WIDTH +: WIDTH] = stage_q[g].data;
      end
   endgenerate

   assign occupancy  = occ_q;
   assign retire_cnt = retire_cnt_q;
   assign bubble_cnt = bubble_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
// ============================================================================
// Module      : tb_pipe_stage_chain
// Description : Directed self-checking bench for pipe_stage_chain (DEPTH=5).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_chain;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [31:0]   in_data;
   logic [4:0]    stall_req;
   logic [4:0]    flush;

   logic          in_ready,    in_ready_c;
   logic [4:0]    stage_valid, stage_valid_c;
   logic [159:0]  stage_data,  stage_data_c;
   logic          out_valid,   out_valid_c;
   logic [31:0]   out_data,    out_data_c;
   logic [2:0]    occupancy,   occupancy_c;
   logic [31:0]   retire_cnt,  retire_cnt_c;
   logic [31:0]   bubble_cnt,  bubble_cnt_c;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_stage_chain #(.WIDTH(32), .DEPTH(5), .COLLAPSE(0), .CNTW(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .stall_req(stall_req), .flush(flush), .stage_valid(stage_valid), .stage_data(stage_data),
      .out_valid(out_valid), .out_data(out_data), .occupancy(occupancy),
      .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
   );

   pipe_stage_chain #(.WIDTH(32), .DEPTH(5), .COLLAPSE(1), .CNTW(32)) dut_c (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_c),
      .stall_req(stall_req), .flush(flush), .stage_valid(stage_valid_c), .stage_data(stage_data_c),
      .out_valid(out_valid_c), .out_data(out_data_c), .occupancy(occupancy_c),
      .retire_cnt(retire_cnt_c), .bubble_cnt(bubble_cnt_c)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = '0; stall_req = '0; flush = '0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b1; in_data = 32'hAA; stall_req = '0; flush = '0;
      step(); step();
      rst = 1'b1;
      step();
      #1;
      total++; if (stage_valid !== 5'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", stage_valid); end
      total++; if (stage_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", stage_data); end
      total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", occupancy); end
      total++; if (retire_cnt !== 32'd0) begin bad++; $display("FAIL reset_retire got=%0d want=0", retire_cnt); end
      total++; if (bubble_cnt !== 32'd0) begin bad++; $display("FAIL reset_bubble got=%0d want=0", bubble_cnt); end
      rst = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_stream();
      logic        ev;
      logic [31:0] ed;
      do_reset();
      for (int c = 0; c < 15; c++) begin
         in_valid = (c < 10);
         in_data  = 32'h10 + 32'(c);
         #1;
         ev = (c >= 5);
         ed = 32'h10 + 32'(c) - 32'd5;
         total++; if (out_valid !== ev) begin bad++; $display("FAIL stream_ov c=%0d got=%b want=%b", c, out_valid, ev); end
         if (ev) begin
            total++; if (out_data !== ed) begin bad++; $display("FAIL stream_od c=%0d got=%h want=%h", c, out_data, ed); end
         end
         if (c == 5) begin
            total++; if (occupancy !== 3'd5) begin bad++; $display("FAIL stream_occ_full got=%0d want=5", occupancy); end
         end
         step();
      end
      in_valid = 1'b0;
      #1;
      total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL stream_occ_drained got=%0d want=0", occupancy); end
      total++; if (retire_cnt !== 32'd10) begin bad++; $display("FAIL stream_retire got=%0d want=10", retire_cnt); end
      total++; if (bubble_cnt !== 32'd5) begin bad++; $display("FAIL stream_bubble got=%0d want=5", bubble_cnt); end
   endtask

   task automatic test_stall_hold();
      logic [31:0] nd;
      logic [31:0] b0, r0;
      logic        e_ov  [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [31:0] e_od  [9] = '{32'h20, 32'h21, 32'h0, 32'h0, 32'h0, 32'h22, 32'h23, 32'h24, 32'h25};
      logic        e_rdy [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      do_reset();
      nd = 32'h20;
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         in_data = nd; step(); nd++;
      end
      b0 = bubble_cnt; r0 = retire_cnt;
      for (int c = 0; c < 9; c++) begin
         stall_req = (c < 3) ? 5'b00100 : 5'b00000;
         in_data   = nd;
         #1;
         total++; if (in_ready !== e_rdy[c]) begin bad++; $display("FAIL stall_rdy c=%0d got=%b want=%b", c, in_ready, e_rdy[c]); end
         total++; if (out_valid !== e_ov[c]) begin bad++; $display("FAIL stall_ov c=%0d got=%b want=%b", c, out_valid, e_ov[c]); end
         if (e_ov[c]) begin
            total++; if (out_data !== e_od[c]) begin bad++; $display("FAIL stall_od c=%0d got=%h want=%h", c, out_data, e_od[c]); end
         end
         if (c == 1) begin
            total++; if (stage_valid !== 5'b10111) begin bad++; $display("FAIL stall_sv1 got=%b want=10111", stage_valid); end
         end
         if (c == 2) begin
            total++; if (stage_valid !== 5'b00111) begin bad++; $display("FAIL stall_sv2 got=%b want=00111", stage_valid); end
         end
         if (e_rdy[c]) nd++;
         step();
      end
      in_valid = 1'b0; stall_req = '0;
      #1;
      total++; if (bubble_cnt !== b0 + 32'd3) begin bad++; $display("FAIL stall_bubble got=%0d want=%0d", bubble_cnt, b0 + 32'd3); end
      total++; if (retire_cnt !== r0 + 32'd6) begin bad++; $display("FAIL stall_retire got=%0d want=%0d", retire_cnt, r0 + 32'd6); end
   endtask

   task automatic test_collapse();
      logic e_rdy [3] = '{1'b1, 1'b1, 1'b0};
      do_reset();
      for (int c = 0; c < 5; c++) begin
         in_valid = (c < 3);
         in_data  = 32'h30 + 32'(c);
         step();
      end
      #1;
      total++; if (stage_valid_c !== 5'b11100) begin bad++; $display("FAIL col_setup got=%b want=11100", stage_valid_c); end
      for (int c = 0; c < 3; c++) begin
         stall_req = 5'b00100;
         in_valid  = 1'b1;
         in_data   = 32'h33 + 32'(c);
         #1;
         total++; if (in_ready_c !== e_rdy[c]) begin bad++; $display("FAIL col_rdy c=%0d got=%b want=%b", c, in_ready_c, e_rdy[c]); end
         if (c == 2) begin
            total++; if (stage_valid_c !== 5'b00111) begin bad++; $display("FAIL col_sv got=%b want=00111", stage_valid_c); end
            total++; if (stage_data_c[31:0] !== 32'h34) begin bad++; $display("FAIL col_s0 got=%h want=34", stage_data_c[31:0]); end
            total++; if (stage_data_c[63:32] !== 32'h33) begin bad++; $display("FAIL col_s1 got=%h want=33", stage_data_c[63:32]); end
            total++; if (stage_data_c[95:64] !== 32'h32) begin bad++; $display("FAIL col_s2 got=%h want=32", stage_data_c[95:64]); end
         end
         step();
      end
      stall_req = '0; in_valid = 1'b0;
   endtask

   task automatic test_flush();
      do_reset();
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         in_data = 32'h40 + 32'(c); step();
      end
      flush = 5'b00100; stall_req = 5'b00010; in_data = 32'h99;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_rdy got=%b want=0", in_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_ov got=%b want=1", out_valid); end
      total++; if (out_data !== 32'h40) begin bad++; $display("FAIL flush_od got=%h want=40", out_data); end
      step();
      flush = '0; stall_req = '0; in_valid = 1'b0;
      #1;
      total++; if ((stage_valid & 5'b10111) !== 5'b10000) begin bad++; $display("FAIL flush_sv got=%b want=1x000", stage_valid); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_ov2 got=%b want=1", out_valid); end
      total++; if (out_data !== 32'h41) begin bad++; $display("FAIL flush_od2 got=%h want=41", out_data); end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         in_data = 32'h50 + 32'(c); step();
      end
      stall_req = 5'b10000; rst = 1'b1;
      step();
      #1;
      total++; if (stage_valid !== 5'b0) begin bad++; $display("FAIL rstm_valid got=%b want=0", stage_valid); end
      total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL rstm_occ got=%0d want=0", occupancy); end
      total++; if (bubble_cnt !== 32'd0) begin bad++; $display("FAIL rstm_bubble got=%0d want=0", bubble_cnt); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstm_ov got=%b want=0", out_valid); end
      rst = 1'b0; stall_req = '0; in_data = 32'h55;
      step();
      in_valid = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         #1;
         total++; if (out_valid !== (c == 5)) begin bad++; $display("FAIL rstm_lat c=%0d got=%b want=%b", c, out_valid, (c == 5)); end
         if (c == 5) begin
            total++; if (out_data !== 32'h55) begin bad++; $display("FAIL rstm_od got=%h want=55", out_data); end
         end
         step();
      end
   endtask

   task automatic test_wrap();
      do_reset();
      in_valid = 1'b1; in_data = 32'h66;
      step();
      in_valid = 1'b0;
      for (int c = 0; c < 4; c++) step();
      stall_req = 5'b10000;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_hold got=%b want=0", out_valid); end
      force dut.retire_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.retire_cnt_q;
      step();
      #1;
      total++; if (retire_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_pre got=%h want=ffffffff", retire_cnt); end
      stall_req = '0;
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL wrap_ov got=%b want=1", out_valid); end
      step();
      #1;
      total++; if (retire_cnt !== 32'd0) begin bad++; $display("FAIL wrap_cnt got=%h want=0", retire_cnt); end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; stall_req = '0; flush = '0;
      @(negedge clk);
      test_reset();
      test_stream();
      test_stall_hold();
      test_collapse();
      test_flush();
      test_reset_midstream();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
